// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode at capture and
// combinational EX/MEM and MEM/WB operand forwarding on the registered operands.
module id_ex_stage #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic         flush,
   input  logic         in_valid,
   input  logic [W-1:0] in_rs_data,
   input  logic [W-1:0] in_rt_data,
   input  logic [W-1:0] in_imm,
   input  logic [4:0]   in_rs,
   input  logic [4:0]   in_rt,
   input  logic [4:0]   in_rd,
   input  logic [1:0]   in_alu_op,
   input  logic [5:0]   in_funct,
   input  logic         in_alu_src,
   input  logic         in_reg_dst,
   input  logic         in_reg_write,
   input  logic         in_mem_read,
   input  logic         in_mem_write,
   input  logic         in_branch,
   input  logic         exm_reg_write,
   input  logic         wb_reg_write,
   input  logic [4:0]   exm_rd,
   input  logic [4:0]   wb_rd,
   input  logic [W-1:0] exm_result,
   input  logic [W-1:0] wb_result,
   output logic [W-1:0] OP1,
   output logic [W-1:0] OP2,
   output logic [3:0]   ALU_Control,
   output logic         out_valid,
   output logic         out_reg_write,
   output logic         out_mem_read,
   output logic         out_mem_write,
   output logic         out_branch,
   output logic [W-1:0] out_rt_data,
   output logic [4:0]   out_dest,
   output logic         out_illegal
);

   logic         valid_q, reg_write_q, mem_read_q, mem_write_q, branch_q, illegal_q;
   logic         alu_src_q;
   logic [3:0]   alu_ctl_q;
   logic [W-1:0] rs_data_q, rt_data_q, imm_q;
   logic [4:0]   rs_q, rt_q, dest_q;

   logic [3:0]   dec_ctl;
   logic         dec_illegal;
   logic [W-1:0] fwd_a, fwd_b;

   always_comb begin
      dec_ctl     = 4'b0010;
      dec_illegal = 1'b0;
      case (in_alu_op)
         2'b00: dec_ctl = 4'b0010;
         2'b01: dec_ctl = 4'b1000;
         2'b10: begin
            case (in_funct)
               6'b100000: dec_ctl = 4'b0010;
               6'b100010: dec_ctl = 4'b0110;
               6'b100100: dec_ctl = 4'b0000;
               6'b100101: dec_ctl = 4'b0001;
               6'b101010: dec_ctl = 4'b0111;
               default:   dec_illegal = 1'b1;
            endcase
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   // Reset and flush leave the stage in the same bubble state.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         branch_q    <= 1'b0;
         illegal_q   <= 1'b0;
         alu_src_q   <= 1'b0;
         alu_ctl_q   <= 4'b0010;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         dest_q      <= '0;
      end else if (!stall) begin
         valid_q     <= in_valid;
         reg_write_q <= in_valid & in_reg_write & ~dec_illegal;
         mem_read_q  <= in_valid & in_mem_read;
         mem_write_q <= in_valid & in_mem_write & ~dec_illegal;
         branch_q    <= in_valid & in_branch;
         illegal_q   <= in_valid & dec_illegal;
         alu_src_q   <= in_alu_src;
         alu_ctl_q   <= dec_ctl;
         rs_data_q   <= in_rs_data;
         rt_data_q   <= in_rt_data;
         imm_q       <= in_imm;
         rs_q        <= in_rs;
         rt_q        <= in_rt;
         dest_q      <= in_reg_dst ? in_rd : in_rt;
      end
   end

   // EX/MEM wins over MEM/WB; r0 is never forwarded.
   always_comb begin
      fwd_a = rs_data_q;
      if (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == rs_q))
         fwd_a = exm_result;
      else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs_q))
         fwd_a = wb_result;

      fwd_b = rt_data_q;
      if (exm_reg_write && (exm_rd != 5'd0) && (exm_rd == rt_q))
         fwd_b = exm_result;
      else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rt_q))
         fwd_b = wb_result;
   end

   assign OP1           = valid_q ? fwd_a : '0;
   assign OP2           = valid_q ? (alu_src_q ? imm_q : fwd_b) : '0;
   assign out_rt_data   = valid_q ? fwd_b : '0;
   assign ALU_Control   = alu_ctl_q;
   assign out_valid     = valid_q;
   assign out_reg_write = reg_write_q;
   assign out_mem_read  = mem_read_q;
   assign out_mem_write = mem_write_q;
   assign out_branch    = branch_q;
   assign out_dest      = dest_q;
   assign out_illegal   = illegal_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: W, 32, datapath width of register operands, immediate and forwarded results.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 Port: stall  input  1  hold all stage registers (load-use hazard).
REQ-005 Port: flush  input  1  replace captured instruction with a bubble.
REQ-006 Port: in_valid  input  1  ID stage presents a valid instruction.
REQ-007 Port: in_rs_data, in_rt_data  input  W each  register-file read data.
REQ-008 Port: in_imm  input  W  sign-extended immediate.
REQ-009 Port: in_rs, in_rt, in_rd  input  5 each  register addresses.
REQ-010 Port: in_alu_op  input  2  00 mem-address add, 01 branch compare, 10 R-type funct decode, 11 reserved.
REQ-011 Port: in_funct  input  6  R-type function field.
REQ-012 Port: in_alu_src, in_reg_dst, in_reg_write, in_mem_read, in_mem_write, in_branch  input  1 each  decoded controls.
REQ-013 Port: exm_reg_write, wb_reg_write  input  1 each  EX/MEM and MEM/WB write enables.
REQ-014 Port: exm_rd, wb_rd  input  5 each  EX/MEM and MEM/WB destinations.
REQ-015 Port: exm_result, wb_result  input  W each  EX/MEM ALU result, MEM/WB write-back data.
REQ-016 Port: OP1, OP2  output  W each  ALU operands.
REQ-017 Port: ALU_Control  output  4  ALU operation code.
REQ-018 Port: out_valid, out_reg_write, out_mem_read, out_mem_write, out_branch  output  1 each  registered controls.
REQ-019 Port: out_rt_data  output  W  forwarded rt value for stores.
REQ-020 Port: out_dest  output  5  write-back register (in_rd if in_reg_dst else in_rt, selected at capture).
REQ-021 Port: out_illegal  output  1  registered: unsupported alu_op/funct captured.

Function
REQ-022 Update priority each edge: rst > flush > stall > capture.
REQ-023 Capture: all in_* fields registered; 1-cycle latency ID->outputs; out_valid = in_valid.
REQ-024 Stall (flush=0): every stage register holds; outputs keep combinational forwarding active.
REQ-025 Flush (overrides stall): out_valid, out_reg_write, out_mem_read, out_mem_write, out_branch, out_illegal = 0; ALU_Control = 0010; data registers = 0.
REQ-026 ALU_Control decoded at capture and registered: alu_op 00 -> 0010; 01 -> 1000.
REQ-027 alu_op 10: funct 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111.
REQ-028 Unlisted funct or alu_op 11 -> ALU_Control 0010, out_illegal=1, out_reg_write/out_mem_write forced 0.
REQ-029 Forward A (rs), combinational: if exm_reg_write & exm_rd!=0 & exm_rd==rs_q -> exm_result; else if wb_reg_write & wb_rd!=0 & wb_rd==rs_q -> wb_result; else rs_data_q.
REQ-030 Forward B (rt) uses same rule with rt_q; EX/MEM always beats MEM/WB when both match.
REQ-031 Register 0 never forwarded; r0 read returns registered value.
REQ-032 OP1 = forward A; OP2 = imm_q if alu_src_q else forward B; out_rt_data = forward B regardless of alu_src.
REQ-033 Forwarding applies only when out_valid=1; bubble outputs OP1=OP2=0.
REQ-034 Simultaneous in_valid=0 capture: stage loads bubble-equivalent controls (reg_write/mem ops/branch 0).

Reset
REQ-035 On rst: out_valid=0, all control outputs 0, ALU_Control=0010, out_illegal=0, all data/address registers 0, OP1=OP2=0.
REQ-036 rst asserted mid-stall or with flush clears stage identically; first capture on first edge after rst deasserts.

Verification
REQ-037 rst held 2 cycles -> all outputs 0, ALU_Control=0010, out_valid=0.
REQ-038 Capture R-type funct 100010, rs_data=9, rt_data=4, no hazards -> next cycle OP1=9, OP2=4, ALU_Control=0110.
REQ-039 rs=5, exm_rd=5, wb_rd=5, both write, exm_result=0xAA, wb_result=0xBB -> OP1=0xAA; exm_rd=0 -> OP1=0xBB.
REQ-040 alu_src=1, imm=0xFFFFFFFC, rt forwarded 0x10 from wb -> OP2=0xFFFFFFFC, out_rt_data=0x10.
REQ-041 stall=1 for 3 cycles with changing in_* -> outputs unchanged; stall=1+flush=1 -> bubble next cycle.
REQ-042 alu_op 10, funct 000000 -> ALU_Control=0010, out_illegal=1, out_reg_write=0.
